// File: rtl/cpu_ctl_pkg.sv
// cpu_ctl_pkg: Funct/ALU/result-mux constants and multiply/divide FSM state shared by the CPU control blocks
package cpu_ctl_pkg;
  localparam logic [5:0] F_sll = 6'd0, F_mfhi = 6'd16, F_mflo = 6'd18, F_multu = 6'd25, F_divu = 6'd27;
  localparam logic [5:0] F_add = 6'd32, F_sub = 6'd34, F_and = 6'd36, F_or = 6'd37, F_slt = 6'd42;
  localparam logic [2:0] ALU_and = 3'b000, ALU_or = 3'b001, ALU_add = 3'b010, ALU_sub = 3'b110, ALU_slt = 3'b111;
  localparam logic [1:0] MUX_alu = 2'b00, MUX_hi = 2'b01, MUX_lo = 2'b10, MUX_shf = 2'b11;
  typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;
endpackage

// File: rtl/muldiv_ctl_if.sv
// muldiv_ctl_if: instruction/operand inputs and decode, handshake and HI/LO outputs of muldiv_ctl
interface muldiv_ctl_if #(parameter int WIDTH = 32);
  logic             op_valid;
  logic [1:0]       ALUOp;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] src_a, src_b;
  logic [2:0]       ALUOperation;
  logic [1:0]       MUXOperation;
  logic             busy, stall;
  logic [WIDTH-1:0] hi, lo;
  modport master (output op_valid, ALUOp, Funct, src_a, src_b,
                  input ALUOperation, MUXOperation, busy, stall, hi, lo);
  modport slave (input op_valid, ALUOp, Funct, src_a, src_b,
                 output ALUOperation, MUXOperation, busy, stall, hi, lo);
endinterface

// File: rtl/alu_decode.sv
// alu_decode: combinational ALUOp/Funct to ALU op code and result-mux select
module alu_decode
  import cpu_ctl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUOperation,
  output logic [1:0] MUXOperation
);
  logic [2:0] r_op;
  logic [1:0] r_mux;
  always_comb begin
    r_op = Funct == F_add ? ALU_add :
           Funct == F_sub ? ALU_sub :
           Funct == F_and ? ALU_and :
           Funct == F_or  ? ALU_or  :
           Funct == F_slt ? ALU_slt : ALU_and;
    r_mux = Funct == F_mfhi ? MUX_hi :
            Funct == F_mflo ? MUX_lo :
            Funct == F_sll  ? MUX_shf : MUX_alu;
    ALUOperation = ALUOp == 2'b00 ? ALU_add :
                   ALUOp == 2'b01 ? ALU_sub :
                   ALUOp == 2'b10 ? r_op : ALU_and;
    MUXOperation = ALUOp == 2'b10 ? r_mux :
                   ALUOp == 2'b11 ? MUX_hi : MUX_alu;
  end
endmodule

// File: rtl/muldiv_ctl.sv
// muldiv_ctl: ALU control decode plus iterative unsigned multiply/divide with HI/LO and busy/stall handshake
module muldiv_ctl
  import cpu_ctl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_ctl_if.slave bus
);
  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] w_hi, w_lo, w_b, hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             md_op, start, last;

  alu_decode u_dec (
    .ALUOp       (bus.ALUOp),
    .Funct       (bus.Funct),
    .ALUOperation(bus.ALUOperation),
    .MUXOperation(bus.MUXOperation)
  );

  assign md_op     = bus.op_valid && bus.ALUOp == 2'b10 && (bus.Funct == F_multu || bus.Funct == F_divu);
  assign start     = md_op && state == IDLE;
  assign last      = cnt == CNT_W'(WIDTH - 1);
  assign bus.busy  = state != IDLE;
  assign bus.stall = bus.op_valid && bus.ALUOp == 2'b10 && bus.busy &&
                     (bus.Funct == F_mfhi || bus.Funct == F_mflo || bus.Funct == F_multu || bus.Funct == F_divu);

  // {w_hi,w_lo} is the shifting product (MUL) or remainder:dividend pair (DIV); w_b is multiplicand/divisor
  always_comb begin
    mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : '0);
    div_sh    = {w_hi, w_lo[WIDTH-1]};
    div_diff  = div_sh - {1'b0, w_b};
    hi_nxt    = state == MUL ? mul_sum[WIDTH:1] :
                div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
    lo_nxt    = state == MUL ? {mul_sum[0], w_lo[WIDTH-1:1]} : {w_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    state_nxt = start ? (bus.Funct == F_multu ? MUL : DIV) :
                state != IDLE && last ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      w_hi   <= '0;
      w_lo   <= '0;
      w_b    <= '0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else if (start) begin
      cnt  <= '0;
      w_hi <= '0;
      w_lo <= bus.Funct == F_multu ? bus.src_b : bus.src_a;
      w_b  <= bus.Funct == F_multu ? bus.src_a : bus.src_b;
    end else if (state != IDLE) begin
      cnt  <= cnt + CNT_W'(1);
      w_hi <= hi_nxt;
      w_lo <= lo_nxt;
      if (last) begin
        bus.hi <= hi_nxt;
        bus.lo <= lo_nxt;
      end
    end
endmodule

// File: tb/tb_muldiv_ctl.sv
// tb_muldiv_ctl: randomized scoreboard bench for muldiv_ctl against an arithmetic reference model
module tb_muldiv_ctl;
  import cpu_ctl_pkg::*;
  localparam int W = 32;

  logic clk = 0, rst_n = 1;
  int errors = 0, checks = 0, cyc = 0, idle_at = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic prev_busy = 0;
  int busy_cycles = 0;

  muldiv_ctl_if #(.WIDTH(W)) bus ();
  muldiv_ctl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct { logic [1:0] op; logic [5:0] f; logic [2:0] alu; logic [1:0] mux; } dec_t;
  dec_t dec_tab[14] = '{
    '{2'b00, 6'd25, 3'b010, 2'b00}, '{2'b01, 6'd0,  3'b110, 2'b00}, '{2'b11, 6'd32, 3'b000, 2'b01},
    '{2'b10, 6'd32, 3'b010, 2'b00}, '{2'b10, 6'd34, 3'b110, 2'b00}, '{2'b10, 6'd36, 3'b000, 2'b00},
    '{2'b10, 6'd37, 3'b001, 2'b00}, '{2'b10, 6'd42, 3'b111, 2'b00}, '{2'b10, 6'd16, 3'b000, 2'b01},
    '{2'b10, 6'd18, 3'b000, 2'b10}, '{2'b10, 6'd0,  3'b000, 2'b11}, '{2'b10, 6'd25, 3'b000, 2'b00},
    '{2'b10, 6'd27, 3'b000, 2'b00}, '{2'b10, 6'd63, 3'b000, 2'b00}
  };

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: full-width product, or quotient/remainder with divide-by-zero giving all-ones/dividend
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f == 6'd25) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = v;
    bus.ALUOp = op;
    bus.Funct = f;
    bus.src_a = a;
    bus.src_b = b;
  endtask

  // holds the request until the model says the unit is idle; returns one step after the accepting edge
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    bit exp_busy;
    drive(1, 2'b10, f, a, b);
    exp_q.push_back(model(f, a, b));
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      exp_busy = cyc < idle_at;
      chk("stall_md", bus.stall, exp_busy);
      chk("busy_md", bus.busy, exp_busy);
      if (!exp_busy) begin
        idle_at = cyc + 1 + W;
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL issue_timeout: request never accepted");
    end else chk("accept_busy", bus.busy, 1);
    bus.op_valid = 0;
  endtask

  task automatic wait_done();
    while (cyc < idle_at) @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_busy = 0;
      busy_cycles = 0;
    end else begin
      if (bus.busy) busy_cycles++;
      else if (prev_busy) begin
        chk("busy_len", 64'(busy_cycles), 64'(W));
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_done: hi=%h lo=%h with no pending result", bus.hi, bus.lo);
        end else begin
          exp_e = exp_q.pop_front();
          chk("hi_lo", {bus.hi, bus.lo}, exp_e);
        end
        busy_cycles = 0;
      end
      prev_busy = bus.busy;
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] f;
    logic [31:0] a, b;
    bit exp_busy;
    drive(0, 2'b00, 6'd0, 0, 0);
    #1 rst_n = 0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    foreach (dec_tab[i]) begin
      drive(0, dec_tab[i].op, dec_tab[i].f, $urandom, $urandom);
      #1;
      chk($sformatf("dec_alu_%0d_%0d", dec_tab[i].op, dec_tab[i].f), bus.ALUOperation, dec_tab[i].alu);
      chk($sformatf("dec_mux_%0d_%0d", dec_tab[i].op, dec_tab[i].f), bus.MUXOperation, dec_tab[i].mux);
    end
    drive(1, 2'b10, F_mfhi, 0, 0);
    #1 chk("stall_idle", bus.stall, 0);
    bus.op_valid = 0;
    @(posedge clk);
    #1;

    issue(F_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    chk("mul_max_hi", bus.hi, 32'hFFFF_FFFE);
    chk("mul_max_lo", bus.lo, 32'h0000_0001);
    issue(F_divu, 100, 7);
    wait_done();
    issue(F_divu, 32'h1234_5678, 0);
    wait_done();

    // mfhi five edges into a multiply stalls until the result lands, then sees the new HI
    issue(F_multu, 32'hDEAD_BEEF, 32'h0001_0003);
    repeat (4) @(posedge clk);
    #1 drive(1, 2'b10, F_mfhi, 0, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      exp_busy = cyc < idle_at;
      chk("stall_mfhi", bus.stall, exp_busy);
      chk("mux_mfhi", bus.MUXOperation, 2'b01);
      if (!exp_busy) begin
        chk("mfhi_new_hi", bus.hi, model(F_multu, 32'hDEAD_BEEF, 32'h0001_0003) >> 32);
        break;
      end
    end
    bus.op_valid = 0;
    @(posedge clk);
    #1;

    issue(F_multu, 32'h0BAD_F00D, 32'h7777_1234);
    repeat (3) @(posedge clk);
    #1 issue(F_multu, 32'h8000_0001, 32'hFFFF_0000);
    issue(F_divu, 32'hFFFF_FFFF, 32'h0000_0010);

    for (int i = 0; i < 16; i++) begin
      f = $urandom_range(0, 1) ? F_divu : F_multu;
      a = $urandom;
      b = (i % 5 == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      issue(f, a, b);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    wait_done();

    // asynchronous reset at step 10 aborts the multiply and clears HI/LO
    issue(F_multu, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    exp_q.delete();
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    idle_at = cyc;
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    issue(F_multu, 3, 5);
    wait_done();
    chk("post_rst_lo", bus.lo, 15);
    chk("post_rst_hi", bus.hi, 0);

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
